rd_track: RTL and testbench

- Parametrised successor to the decode-stage destination-register selector in the RISC-V pipeline CPU.
- Decodes the destination register from the incoming instruction; the configurable alternate opcode takes its destination from rs1.
- Carries the destination register and a write-valid flag through a configurable number of downstream pipeline stages, with stall and flush.
- Flags RAW hazards of the decoding instruction against in-flight destinations. Sits beside the ID stage; feeds the hazard unit and the WB write port.

---
 rtl/rd_track.sv | 103 ++++++++++
 tb/tb_rd_track.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rd_track.sv
// Destination-register tracker beside ID: decodes rd, carries {rd, write-valid}
// through the downstream stages, and flags RAW hazards of the decoding instruction.
module rd_track_match (
  input  logic [4:0] stage_rd,
  input  logic       stage_vld,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = stage_vld && (stage_rd == rs1);
  assign hit2 = stage_vld && (stage_rd == rs2);
endmodule

module rd_track #(
  parameter int         NUM_STAGES   = 3,
  parameter int         FLUSH_STAGES = 1,
  parameter bit         ALT_EN       = 1'b1,
  parameter logic [4:0] ALT_OPCODE   = 5'b01010,
  localparam int        DW           = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             instr_i,
  input  logic                    instr_valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [4:0]              rd_addr_o,
  output logic [5*NUM_STAGES-1:0] stage_rd_o,
  output logic [NUM_STAGES-1:0]   stage_vld_o,
  output logic [4:0]              wb_rd_o,
  output logic                    wb_we_o,
  output logic                    haz_rs1_o,
  output logic                    haz_rs2_o,
  output logic [DW-1:0]           haz_dist_o
);
  logic [4:0] opcode, rs1, rs2;
  logic       we, rs1_use, rs2_use, rs1_chk, rs2_chk;
  logic [NUM_STAGES-1:0][4:0] rd_pipe;
  logic [NUM_STAGES-1:0]      vld_pipe;
  logic [NUM_STAGES-1:0]      hit1, hit2, hit;
  logic                       unused_bits;

  assign opcode    = instr_i[6:2];
  assign rs1       = instr_i[19:15];
  assign rs2       = instr_i[24:20];
  assign rd_addr_o = (ALT_EN && opcode == ALT_OPCODE) ? rs1 : instr_i[11:7];

  // stores and branches carry an rd field that is really immediate bits
  assign we = instr_valid_i && (rd_addr_o != 5'd0) &&
              (opcode != 5'b01000) && (opcode != 5'b11000);

  assign rs1_use = !(opcode inside {5'b01101, 5'b00101, 5'b11011});
  assign rs2_use =   opcode inside {5'b01100, 5'b01000, 5'b11000};
  assign rs1_chk = instr_valid_i && rs1_use && (rs1 != 5'd0);
  assign rs2_chk = instr_valid_i && rs2_use && (rs2 != 5'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pipe  <= '0;
      vld_pipe <= '0;
    end else if (!stall_i) begin
      rd_pipe[0]  <= rd_addr_o;
      vld_pipe[0] <= we && !flush_i;
      for (int k = 1; k < NUM_STAGES; k++) begin
        rd_pipe[k]  <= rd_pipe[k-1];
        // entries that were younger than FLUSH_STAGES before the edge die here
        vld_pipe[k] <= vld_pipe[k-1] && !(flush_i && k <= FLUSH_STAGES);
      end
    end else if (flush_i) begin
      for (int k = 0; k < FLUSH_STAGES; k++) vld_pipe[k] <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    rd_track_match u_match (
      .stage_rd  (rd_pipe[k]),
      .stage_vld (vld_pipe[k]),
      .rs1       (rs1),
      .rs2       (rs2),
      .hit1      (hit1[k]),
      .hit2      (hit2[k])
    );
    assign hit[k] = (hit1[k] && rs1_chk) || (hit2[k] && rs2_chk);
  end

  assign haz_rs1_o = rs1_chk && (|hit1);
  assign haz_rs2_o = rs2_chk && (|hit2);

  // descending scan so the youngest matching stage wins
  always_comb begin
    haz_dist_o = '0;
    for (int k = NUM_STAGES-1; k >= 0; k--)
      if (hit[k]) haz_dist_o = DW'(k);
  end

  assign stage_rd_o  = rd_pipe;
  assign stage_vld_o = vld_pipe;
  assign wb_rd_o     = rd_pipe[NUM_STAGES-1];
  assign wb_we_o     = vld_pipe[NUM_STAGES-1];

  assign unused_bits = ^{instr_i[31:25], instr_i[14:12], instr_i[1:0]};
endmodule

// File: tb/tb_rd_track.sv
// Directed vector bench for rd_track (NUM_STAGES=3, FLUSH_STAGES=1).
module tb_rd_track;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i, stall_i, flush_i;
  logic [4:0]  rd_addr_o, wb_rd_o;
  logic [14:0] stage_rd_o;
  logic [2:0]  stage_vld_o;
  logic        wb_we_o, haz_rs1_o, haz_rs2_o;
  logic [1:0]  haz_dist_o;

  logic [4:0]  alt0_rd;
  logic [14:0] unused_srd;
  logic [2:0]  unused_svld;
  logic [4:0]  unused_wbrd;
  logic        unused_we, unused_h1, unused_h2;
  logic [1:0]  unused_dist;

  always #5 clk_i = ~clk_i;

  rd_track dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .rd_addr_o(rd_addr_o),
    .stage_rd_o(stage_rd_o), .stage_vld_o(stage_vld_o), .wb_rd_o(wb_rd_o),
    .wb_we_o(wb_we_o), .haz_rs1_o(haz_rs1_o), .haz_rs2_o(haz_rs2_o),
    .haz_dist_o(haz_dist_o)
  );

  rd_track #(.ALT_EN(1'b0)) dut_noalt (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .rd_addr_o(alt0_rd),
    .stage_rd_o(unused_srd), .stage_vld_o(unused_svld), .wb_rd_o(unused_wbrd),
    .wb_we_o(unused_we), .haz_rs1_o(unused_h1), .haz_rs2_o(unused_h2),
    .haz_dist_o(unused_dist)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vin, stall, flush;
    logic [4:0]  e_rd;
    logic        e_h1, e_h2;
    logic [1:0]  e_dist;
    logic [2:0]  e_svld;
    logic        e_we;
    logic [4:0]  e_wbrd;
    logic        chk_srd;
    logic [14:0] e_srd;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op, 2'b11};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(logic [31:0] instr, logic vin, logic st, logic fl,
                     logic [4:0] e_rd, logic e_h1, logic e_h2, logic [1:0] e_dist,
                     logic [2:0] e_svld, logic e_we, logic [4:0] e_wbrd,
                     logic chk_srd, logic [14:0] e_srd);
    vec_t v;
    v.instr = instr; v.vin = vin; v.stall = st; v.flush = fl;
    v.e_rd = e_rd; v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_dist = e_dist;
    v.e_svld = e_svld; v.e_we = e_we; v.e_wbrd = e_wbrd;
    v.chk_srd = chk_srd; v.e_srd = e_srd;
    vecs.push_back(v);
  endtask

  localparam logic [4:0] OP_IMM = 5'b00100, OP_R = 5'b01100, OP_S = 5'b01000,
                         OP_B = 5'b11000, OP_LUI = 5'b01101, OP_AUIPC = 5'b00101,
                         OP_JAL = 5'b11011, OP_ALT = 5'b01010;

  initial begin
    //   instr                  v st fl  rd h1 h2 dist  svld   we wbrd chk srd
    add(mk(OP_IMM,  5, 0, 0),  1, 0, 0,  5, 0, 0, 0, 3'b001, 0, 0, 0, '0);
    add(mk(OP_R,    6, 5, 5),  1, 0, 0,  6, 1, 1, 0, 3'b011, 0, 0, 0, '0);
    add(mk(OP_R,    8, 5, 0),  1, 0, 0,  8, 1, 0, 1, 3'b111, 1, 5, 0, '0);
    add(mk(OP_LUI,  7, 5, 0),  1, 0, 0,  7, 0, 0, 0, 3'b111, 1, 6, 0, '0);
    add(mk(OP_S,    9, 8, 7),  1, 0, 0,  9, 1, 1, 0, 3'b110, 1, 8, 0, '0);
    add(mk(OP_IMM,  0, 7, 0),  1, 0, 0,  0, 1, 0, 1, 3'b100, 1, 7, 0, '0);
    add(mk(OP_ALT,  3, 7, 0),  1, 0, 0,  7, 1, 0, 2, 3'b001, 0, 0, 0, '0);
    add(mk(OP_B,    4, 7, 7),  1, 0, 0,  4, 1, 1, 0, 3'b010, 0, 0, 0, '0);
    add(mk(OP_IMM, 10, 7, 0),  0, 0, 0, 10, 0, 0, 0, 3'b100, 1, 7, 0, '0);
    add(mk(OP_JAL,  1, 7, 0),  1, 0, 0,  1, 0, 0, 0, 3'b001, 0, 0, 0, '0);
    add(mk(OP_AUIPC,2, 1, 0),  1, 0, 0,  2, 0, 0, 0, 3'b011, 0, 0, 0, '0);
    add(mk(OP_R,    3, 1, 2),  1, 0, 0,  3, 1, 1, 0, 3'b111, 1, 1, 1, {5'd1, 5'd2, 5'd3});
    add(mk(OP_IMM,  9, 3, 0),  1, 1, 0,  9, 1, 0, 0, 3'b111, 1, 1, 1, {5'd1, 5'd2, 5'd3});
    add(mk(OP_R,    4, 2, 1),  1, 1, 0,  4, 1, 1, 1, 3'b111, 1, 1, 1, {5'd1, 5'd2, 5'd3});
    add(mk(OP_IMM,  9, 0, 0),  1, 0, 1,  9, 0, 0, 0, 3'b100, 1, 2, 0, '0);
    add(mk(OP_IMM, 11, 0, 0),  1, 0, 0, 11, 0, 0, 0, 3'b001, 0, 0, 0, '0);
    add(mk(OP_IMM, 12, 0, 0),  1, 1, 1, 12, 0, 0, 0, 3'b000, 0, 0, 0, '0);
    add(mk(OP_IMM, 13, 0, 0),  1, 0, 0, 13, 0, 0, 0, 3'b001, 0, 0, 0, '0);
    add(mk(OP_IMM, 14, 0, 0),  1, 0, 1, 14, 0, 0, 0, 3'b000, 0, 0, 0, '0);

    rst_i = 1'b0; instr_i = '0; instr_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_vld", stage_vld_o, 0);
    chk("reset_srd", stage_rd_o, 0);
    chk("reset_wb", {wb_we_o, wb_rd_o}, 0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_vld", stage_vld_o, 0);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      instr_i = vecs[i].instr; instr_valid_i = vecs[i].vin;
      stall_i = vecs[i].stall; flush_i = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_rd", i), rd_addr_o, vecs[i].e_rd);
      chk($sformatf("v%0d_h1", i), haz_rs1_o, vecs[i].e_h1);
      chk($sformatf("v%0d_h2", i), haz_rs2_o, vecs[i].e_h2);
      chk($sformatf("v%0d_dist", i), haz_dist_o, vecs[i].e_dist);
      if (vecs[i].instr[6:2] == OP_ALT)
        chk($sformatf("v%0d_noalt_rd", i), alt0_rd, vecs[i].instr[11:7]);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d_svld", i), stage_vld_o, vecs[i].e_svld);
      chk($sformatf("v%0d_wbwe", i), wb_we_o, vecs[i].e_we);
      if (vecs[i].e_we) chk($sformatf("v%0d_wbrd", i), wb_rd_o, vecs[i].e_wbrd);
      if (vecs[i].chk_srd) chk($sformatf("v%0d_srd", i), stage_rd_o, vecs[i].e_srd);
    end

    // fill all stages, then drop reset between edges
    @(negedge clk_i);
    stall_i = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      instr_i = mk(OP_IMM, 5'(r + 20), 0, 0);
      @(negedge clk_i);
    end
    chk("full_vld", stage_vld_o, 7);
    chk("full_wbrd", wb_rd_o, 21);
    #2 rst_i = 1'b0;
    #1;
    chk("async_vld", stage_vld_o, 0);
    chk("async_wbwe", wb_we_o, 0);
    chk("async_srd", stage_rd_o, 0);
    chk("async_comb_rd", rd_addr_o, 23);
    #3 rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("post_reset_vld", stage_vld_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
